// File: rtl/nbody_pkg.sv
// nbody_pkg -- shared types and helpers for the N-body engine.
//   body_t      : packed body record {x, y, vx, vy, mass}, 80 bits, x in the MSBs.
//                 Position/velocity fields are signed Q-format 16-bit, mass is unsigned.
//   S16_MAX/MIN : clamp limits for signed 16-bit fields.
//   sat16       : clamps a 33-bit signed value into the signed 16-bit range.
//   neg_sat16   : saturating negation (-32768 maps to 32767).
// Shared by the integrator, the force calculator and the simulation top.
package nbody_pkg;

   typedef struct packed {
      logic signed [15:0] x;
      logic signed [15:0] y;
      logic signed [15:0] vx;
      logic signed [15:0] vy;
      logic        [15:0] mass;
   } body_t;

   localparam logic signed [15:0] S16_MAX = 16'sh7FFF;
   localparam logic signed [15:0] S16_MIN = 16'sh8000;

   function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
      if (v > 33'sd32767) begin
         return S16_MAX;
      end else if (v < -33'sd32768) begin
         return S16_MIN;
      end
      return v[15:0];
   endfunction

   function automatic logic signed [15:0] neg_sat16(input logic signed [15:0] v);
      if (v == S16_MIN) begin
         return S16_MAX;
      end
      return -v;
   endfunction

endpackage

// File: rtl/body_integrator_if.sv
// body_integrator_if -- streaming handshake bundle around the integrator.
//   in_valid/in_ready   : input record handshake
//   in_body             : body record to integrate
//   in_fx/in_fy         : signed 32-bit accumulated force sums
//   out_valid/out_ready : output record handshake
//   out_body            : integrated body record
// Modports: master = producer of records / consumer of results,
//           slave  = the integrator itself.
interface body_integrator_if;
   import nbody_pkg::*;

   logic               in_valid;
   logic               in_ready;
   body_t              in_body;
   logic signed [31:0] in_fx;
   logic signed [31:0] in_fy;
   logic               out_valid;
   logic               out_ready;
   body_t              out_body;

   modport master (
      output in_valid, in_body, in_fx, in_fy, out_ready,
      input  in_ready, out_valid, out_body
   );

   modport slave (
      input  in_valid, in_body, in_fx, in_fy, out_ready,
      output in_ready, out_valid, out_body
   );

endinterface

// File: rtl/sat_add16.sv
// sat_add16 -- combinational signed 16-bit + signed 32-bit saturating adder.
//   a     : signed 16-bit operand
//   b     : signed 32-bit operand
//   sum   : a + b clamped to [-32768, 32767]
//   clamp : high when the exact sum fell outside the 16-bit range
// The sum is formed at 33 bits so no intermediate overflow is possible.
module sat_add16
   import nbody_pkg::*;
(
   input  logic signed [15:0] a,
   input  logic signed [31:0] b,
   output logic signed [15:0] sum,
   output logic               clamp
);

   logic signed [32:0] wide;

   assign wide  = $signed({{17{a[15]}}, a}) + $signed({b[31], b});
   assign sum   = sat16(wide);
   assign clamp = (wide > 33'sd32767) || (wide < -33'sd32768);

endmodule

// File: rtl/body_integrator.sv
// body_integrator -- semi-implicit Euler update of one body per cycle.
//   clk         : system clock
//   reset       : synchronous, active-high; flushes all in-flight records
//   bus         : body_integrator_if.slave (in/out valid-ready streams)
//   clear_flags : clears sat_flag (a coincident new saturation wins)
//   sat_flag    : sticky, set when any velocity or position update clamps
//   out_count   : output handshakes, wraps modulo 2^CNT_W
// Pipeline: S1 registers body and dv = f >>> DT_SHIFT, S2 registers the
// clamped velocities, S3 registers the clamped positions (this is out_body).
// All stages advance together on adv = !out_valid || out_ready.
// Optional feature: define NBODY_BOUNCE_EN to reflect velocity on a clamped
// position (reflecting walls); otherwise velocity is left unchanged.
module body_integrator
   import nbody_pkg::*;
#(
   parameter int DT_SHIFT  = 4,
   parameter int POS_SHIFT = 2,
   parameter int CNT_W     = 8
) (
   input  logic               clk,
   input  logic               reset,
   body_integrator_if.slave   bus,
   input  logic               clear_flags,
   output logic               sat_flag,
   output logic [CNT_W-1:0]   out_count
);

   logic adv;
   assign adv          = !bus.out_valid || bus.out_ready;
   assign bus.in_ready = adv;

   logic  s1_valid, s2_valid, s3_valid;
   body_t s1_body, s2_body, s3_body;
   body_t s2_next, s3_next;

   logic signed [31:0] in_f      [2];
   logic signed [31:0] s1_dvel   [2];
   logic signed [15:0] vel_in    [2];
   logic signed [15:0] vel_new   [2];
   logic signed [15:0] vel_s2    [2];
   logic signed [15:0] pos_in    [2];
   logic signed [31:0] dpos      [2];
   logic signed [15:0] pos_new   [2];
   logic signed [15:0] vel_out   [2];
   logic [1:0]         vel_clamp;
   logic [1:0]         pos_clamp;

   assign in_f[0]   = bus.in_fx;
   assign in_f[1]   = bus.in_fy;
   assign vel_in[0] = s1_body.vx;
   assign vel_in[1] = s1_body.vy;
   assign vel_s2[0] = s2_body.vx;
   assign vel_s2[1] = s2_body.vy;
   assign pos_in[0] = s2_body.x;
   assign pos_in[1] = s2_body.y;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_axis
         // Arithmetic shift floors toward -inf, so tiny negative forces still nudge velocity.
         always_ff @(posedge clk) begin
            if (adv) begin
               s1_dvel[gi] <= in_f[gi] >>> DT_SHIFT;
            end
         end

         sat_add16 u_vel (
            .a     (vel_in[gi]),
            .b     (s1_dvel[gi]),
            .sum   (vel_new[gi]),
            .clamp (vel_clamp[gi])
         );

         // Shift at 16 bits then sign-extend into the adder's wide operand.
         assign dpos[gi] = 32'(vel_s2[gi] >>> POS_SHIFT);

         sat_add16 u_pos (
            .a     (pos_in[gi]),
            .b     (dpos[gi]),
            .sum   (pos_new[gi]),
            .clamp (pos_clamp[gi])
         );

`ifdef NBODY_BOUNCE_EN
         assign vel_out[gi] = pos_clamp[gi] ? neg_sat16(vel_s2[gi]) : vel_s2[gi];
`else
         assign vel_out[gi] = vel_s2[gi];
`endif
      end
   endgenerate

   always_comb begin
      s2_next    = s1_body;
      s2_next.vx = vel_new[0];
      s2_next.vy = vel_new[1];
   end

   always_comb begin
      s3_next    = s2_body;
      s3_next.x  = pos_new[0];
      s3_next.y  = pos_new[1];
      s3_next.vx = vel_out[0];
      s3_next.vy = vel_out[1];
   end

   // Data registers only need an enable; valids and the visible output are reset.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_body <= bus.in_body;
         s2_body <= s2_next;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         s3_body  <= '0;
      end else if (adv) begin
         s1_valid <= bus.in_valid;
         s2_valid <= s1_valid;
         s3_valid <= s2_valid;
         s3_body  <= s3_next;
      end
   end

   assign bus.out_valid = s3_valid;
   assign bus.out_body  = s3_body;

   // Clamps on stale data in empty stages are masked by the stage valid.
   logic sat_set;
   assign sat_set = adv && ((s1_valid && (|vel_clamp)) || (s2_valid && (|pos_clamp)));

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_flag <= 1'b0;
      end else if (sat_set) begin
         sat_flag <= 1'b1;
      end else if (clear_flags) begin
         sat_flag <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_count <= '0;
      end else if (bus.out_valid && bus.out_ready) begin
         out_count <= out_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_body_integrator.sv
// tb_body_integrator -- self-checking bench for body_integrator.
// Directed cases for nominal update, floor shift, position/velocity clamps,
// backpressure and mid-flight reset, then a randomized stream with random
// output backpressure scored against an arithmetic reference model.
// Honours NBODY_BOUNCE_EN for the expected wall behaviour.
module tb_body_integrator;
   import nbody_pkg::*;

   localparam int DT_SHIFT  = 4;
   localparam int POS_SHIFT = 2;
   localparam int CNT_W     = 8;

   typedef struct {
      body_t b;
      logic  sat;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             clear_flags = 1'b0;
   logic             sat_flag;
   logic [CNT_W-1:0] out_count;

   body_integrator_if bus();

   body_integrator #(
      .DT_SHIFT  (DT_SHIFT),
      .POS_SHIFT (POS_SHIFT),
      .CNT_W     (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .clear_flags (clear_flags),
      .sat_flag    (sat_flag),
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    failures = 0;
   exp_t  exp_q[$];
   int    model_cnt = 0;
   logic  exp_sat_any = 1'b0;
   body_t last_out = '0;

   task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic body_t mk(input int x, input int y, input int vx, input int vy, input int m);
      body_t b;
      b.x    = 16'(x);
      b.y    = 16'(y);
      b.vx   = 16'(vx);
      b.vy   = 16'(vy);
      b.mass = 16'(m);
      return b;
   endfunction

   function automatic longint clamp16(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   // Mathematical floor division for positive divisors.
   function automatic longint floor_div(input longint a, input longint d);
      longint q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic exp_t ref_model(input body_t b, input logic signed [31:0] fx,
                                      input logic signed [31:0] fy);
      exp_t   r;
      longint p[2], v[2], f[2];
      longint nv, np;
      p[0] = b.x;  p[1] = b.y;
      v[0] = b.vx; v[1] = b.vy;
      f[0] = fx;   f[1] = fy;
      r.b = b;
      r.sat = 1'b0;
      for (int k = 0; k < 2; k++) begin
         nv = v[k] + floor_div(f[k], longint'(1) << DT_SHIFT);
         if (nv != clamp16(nv)) r.sat = 1'b1;
         nv = clamp16(nv);
         np = p[k] + floor_div(nv, longint'(1) << POS_SHIFT);
         if (np != clamp16(np)) begin
            r.sat = 1'b1;
`ifdef NBODY_BOUNCE_EN
            nv = (nv == -32768) ? 32767 : -nv;
`endif
         end
         np = clamp16(np);
         if (k == 0) begin
            r.b.x  = 16'(np);
            r.b.vx = 16'(nv);
         end else begin
            r.b.y  = 16'(np);
            r.b.vy = 16'(nv);
         end
      end
      return r;
   endfunction

   // Scoreboard: sampled mid-cycle, so values seen here are what the next edge acts on.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         exp_q.delete();
         model_cnt = 0;
         exp_sat_any = 1'b0;
      end else begin
         if (clear_flags) exp_sat_any = 1'b0;
         if (bus.out_valid && bus.out_ready) begin
            check_val("out_count", 80'(out_count), 80'(model_cnt % 256));
            if (exp_q.size() == 0) begin
               check_val("out_unexpected", 80'(bus.out_valid), 80'(0));
            end else begin
               e = exp_q.pop_front();
               check_val("out_body", bus.out_body, e.b);
            end
            $display("OUT %0d x=%0d y=%0d vx=%0d vy=%0d m=%0d", model_cnt,
                     bus.out_body.x, bus.out_body.y, bus.out_body.vx, bus.out_body.vy,
                     bus.out_body.mass);
            last_out = bus.out_body;
            model_cnt++;
         end
         if (bus.in_valid && bus.in_ready) begin
            e = ref_model(bus.in_body, bus.in_fx, bus.in_fy);
            exp_q.push_back(e);
            exp_sat_any = exp_sat_any | e.sat;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // All driver tasks start and end at posedge+1.
   task automatic send(input body_t b, input logic [31:0] fx, input logic [31:0] fy);
      int guard = 0;
      bus.in_valid = 1'b1;
      bus.in_body  = b;
      bus.in_fx    = fx;
      bus.in_fy    = fy;
      @(negedge clk);
      while (!bus.in_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) check_val("send_timeout", 80'(bus.in_ready), 80'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int guard = 0;
      bus.out_ready = 1'b1;
      while ((exp_q.size() != 0 || bus.out_valid) && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 200) check_val("drain_timeout", 80'(exp_q.size()), 80'(0));
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1;
      clear_flags = 1'b1;
      @(posedge clk); #1;
      clear_flags = 1'b0;
   endtask

   task automatic measure_latency(input string tag);
      int n = 0;
      while (n < 10) begin
         @(negedge clk);
         n++;
         if (bus.out_valid) break;
      end
      check_val(tag, 80'(n), 80'(3));
      @(posedge clk); #1;
   endtask

   initial begin
      body_t b;
      body_t held;
      logic  done;
      bus.in_valid  = 1'b0;
      bus.in_body   = '0;
      bus.in_fx     = '0;
      bus.in_fy     = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_out_valid", 80'(bus.out_valid), 80'(0));
      check_val("rst_out_body", bus.out_body, 80'(0));
      check_val("rst_sat_flag", 80'(sat_flag), 80'(0));
      check_val("rst_out_count", 80'(out_count), 80'(0));
      check_val("rst_in_ready", 80'(bus.in_ready), 80'(1));
      @(posedge clk); #1;
      reset = 1'b0;

      // Nominal update and latency
      send(mk(100, -50, 10, -4, 7), 32'sd160, -32'sd64);
      measure_latency("nominal_latency");
      drain();
      check_val("nominal_body", last_out, mk(105, -52, 20, -8, 7));
      check_val("nominal_sat", 80'(sat_flag), 80'(0));
      check_val("nominal_count", 80'(out_count), 80'(1));

      // Floor shift
      send(mk(0, 0, 0, 0, 1), -32'sd1, 32'sd0);
      drain();
      check_val("floor_neg", last_out, mk(-1, 0, -1, 0, 1));
      send(mk(0, 0, 0, 0, 1), 32'sd15, 32'sd0);
      drain();
      check_val("floor_pos", last_out, mk(0, 0, 0, 0, 1));
      check_val("floor_sat", 80'(sat_flag), 80'(0));

      // Position saturation
      send(mk(32760, 0, 100, 0, 3), 32'sd0, 32'sd0);
      drain();
`ifdef NBODY_BOUNCE_EN
      check_val("pos_sat_body", last_out, mk(32767, 0, -100, 0, 3));
`else
      check_val("pos_sat_body", last_out, mk(32767, 0, 100, 0, 3));
`endif
      check_val("pos_sat_flag", 80'(sat_flag), 80'(1));
      pulse_clear();
      @(negedge clk);
      check_val("clear_flag", 80'(sat_flag), 80'(0));
      @(posedge clk); #1;

      // Velocity clamp both directions
      send(mk(0, 0, 32000, 0, 1), 32'h7FFF_FFFF, 32'sd0);
      drain();
      check_val("vel_clamp_hi", last_out, mk(8191, 0, 32767, 0, 1));
      check_val("vel_clamp_flag", 80'(sat_flag), 80'(1));
      send(mk(0, 0, -32000, 0, 1), 32'h8000_0000, 32'sd0);
      drain();
      check_val("vel_clamp_lo", last_out, mk(-8192, 0, -32768, 0, 1));
      pulse_clear();

      // Backpressure: stall the output while five records stream in
      do_reset();
      fork
         begin
            for (int i = 0; i < 5; i++) begin
               send(mk(i * 10, -i * 10, i, -i, i), 32'(i * 32), 32'(-i * 16));
            end
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            held = bus.out_body;
            for (int k = 0; k < 6; k++) begin
               @(negedge clk);
               check_val("bp_in_ready", 80'(bus.in_ready), 80'(0));
               check_val("bp_hold", bus.out_body, held);
            end
            @(posedge clk); #1;
            bus.out_ready = 1'b1;
         end
      join
      drain();
      check_val("bp_count", 80'(out_count), 80'(5));
      b = ref_model(mk(40, -40, 4, -4, 4), 32'sd128, -32'sd64).b;
      check_val("bp_last", last_out, b);

      // Reset while two records are in flight
      send(mk(1, 2, 3, 4, 5), 32'sd16, 32'sd16);
      send(mk(6, 7, 8, 9, 10), 32'sd16, 32'sd16);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_val("flush_out_valid", 80'(bus.out_valid), 80'(0));
         check_val("flush_out_count", 80'(out_count), 80'(0));
      end
      @(posedge clk); #1;
      send(mk(200, 300, -8, 8, 9), -32'sd32, 32'sd32);
      measure_latency("fresh_latency");
      drain();
      check_val("fresh_body", last_out, mk(197, 302, -10, 10, 9));

      // Randomized stream with random backpressure
      do_reset();
      pulse_clear();
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [31:0] fx, fy;
               b.x    = ($urandom_range(0, 3) == 0) ? 16'(32767 - $urandom_range(0, 40)) : 16'($urandom);
               b.y    = ($urandom_range(0, 3) == 0) ? 16'(-32768 + $urandom_range(0, 40)) : 16'($urandom);
               b.vx   = 16'($urandom);
               b.vy   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 200)) : 16'($urandom);
               b.mass = 16'($urandom);
               fx = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 2047)) - 32'd1024;
               fy = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 2047)) - 32'd1024;
               send(b, fx, fy);
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk); #1;
               end
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      drain();
      check_val("rand_queue_empty", 80'(exp_q.size()), 80'(0));
      check_val("rand_count", 80'(out_count), 80'(model_cnt % 256));
      check_val("rand_sat_flag", 80'(sat_flag), 80'(exp_sat_any));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
